// File: rtl/fifo_wr_arbiter_if.sv
// Producer/fifo write-side bundle for fifo_wr_arbiter.
// master: producers plus fifo occupancy feedback; slave: the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 4
);
  logic [N_REQ*DWIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [DWIDTH-1:0]       fifo_data_o;
  logic                    fifo_wrreq_o;
  logic [AWIDTH:0]         fifo_usedw_i;

  modport master (
    output req_data_i, req_valid_i, fifo_usedw_i,
    input  req_ready_o, fifo_data_o, fifo_wrreq_o
  );

  modport slave (
    input  req_data_i, req_valid_i, fifo_usedw_i,
    output req_ready_o, fifo_data_o, fifo_wrreq_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst hold in front of a single fifo.
// Occupancy feedback (usedw plus the word still in the output register)
// keeps the fifo from ever being written while full.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add the saturating stall_cnt_o.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  fifo_wr_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant_id_o
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned SW  = AWIDTH + 2;
  localparam int unsigned CW  = 8;
  localparam logic [SW-1:0] DEPTH = SW'(2 ** AWIDTH);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_d;
  logic [CW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [IDW-1:0] sel_c, idx_c;
  logic [SW-1:0]  fill_c;
  logic           space_c, any_valid_c, accept_c;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (32'(i) + 32'd1 == N_REQ) ? '0 : i + IDW'(1);
  endfunction

  // Fill level as seen by the fifo once the registered word lands
  assign fill_c  = SW'(bus.fifo_usedw_i) + SW'(bus.fifo_wrreq_o);
  assign space_c = fill_c < DEPTH;

  // Source select: rotating priority from rr_ptr in ARB, current owner in BURST
  always_comb begin
    sel_c       = rr_ptr_q;
    idx_c       = '0;
    any_valid_c = 1'b0;
    if (state_q == ST_BURST) begin
      sel_c       = grant_id_o;
      any_valid_c = bus.req_valid_i[grant_id_o];
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx_c = IDW'((32'(rr_ptr_q) + k) % N_REQ);
        if (!any_valid_c && bus.req_valid_i[idx_c]) begin
          sel_c       = idx_c;
          any_valid_c = 1'b1;
        end
      end
    end
  end

  // One-hot ready, held low while in reset or when the fifo has no room
  always_comb begin
    bus.req_ready_o = '0;
    if (arstn_i && space_c && any_valid_c) begin
      bus.req_ready_o[sel_c] = 1'b1;
    end
  end

  assign accept_c = bus.req_valid_i[sel_c] & bus.req_ready_o[sel_c];

  // Next-state and grant bookkeeping
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = grant_id_o;
    case (state_q)
      ST_ARB: begin
        if (accept_c) begin
          grant_d = sel_c;
          if (MAX_BURST > 1) begin
            state_d     = ST_BURST;
            burst_cnt_d = CW'(1);
          end else begin
            rr_ptr_d = next_idx(sel_c);
          end
        end
      end
      default: begin
        if (!bus.req_valid_i[grant_id_o]) begin
          // Owner went idle: release immediately
          state_d     = ST_ARB;
          rr_ptr_d    = next_idx(grant_id_o);
          burst_cnt_d = '0;
        end else if (accept_c) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
          if (32'(burst_cnt_q) + 32'd1 == MAX_BURST) begin
            state_d  = ST_ARB;
            rr_ptr_d = next_idx(grant_id_o);
          end
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Round-robin pointer, burst counter and grant registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      grant_id_o  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_id_o  <= grant_d;
    end
  end

  // Output stage: one accepted word becomes one fifo write a cycle later
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      bus.fifo_wrreq_o <= 1'b0;
      bus.fifo_data_o  <= '0;
    end else begin
      bus.fifo_wrreq_o <= accept_c;
      if (accept_c) begin
        bus.fifo_data_o <= bus.req_data_i[32'(sel_c)*DWIDTH +: DWIDTH];
      end
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  // Saturating count of cycles where someone wants to write but there is no room
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      stall_cnt_o <= '0;
    end else if ((|bus.req_valid_i) && !space_c && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (4 producers / burst 4 / depth 4,
// and 3 producers / burst 1 / depth 16) run in lockstep against a fifo model
// and a rule-level arbitration model.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NA = 4;
  localparam int AA = 2;
  localparam int MA = 4;
  localparam int NB = 3;
  localparam int AB = 4;
  localparam int MB = 1;

  logic clk = 1'b0;
  logic arstn;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  fifo_wr_arbiter_if #(.N_REQ(NA), .DWIDTH(DW), .AWIDTH(AA)) if_a ();
  fifo_wr_arbiter_if #(.N_REQ(NB), .DWIDTH(DW), .AWIDTH(AB)) if_b ();

  logic [1:0]  gnt_a, gnt_b;
  logic [15:0] vld [2];
  logic [31:0] dat [2][16];
  int          size [2];
  bit          pend_wr [2];
  bit          pend_rd [2];
  logic [15:0] rdy_a, rdy_b;

  int nreq [2]   = '{NA, NB};
  int depth [2]  = '{1 << AA, 1 << AB};
  int mburst [2] = '{MA, MB};

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif

  fifo_wr_arbiter #(.N_REQ(NA), .DWIDTH(DW), .AWIDTH(AA), .MAX_BURST(MA)) u_dut_a (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .bus        (if_a),
    .grant_id_o (gnt_a)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_a)
`endif
  );

  fifo_wr_arbiter #(.N_REQ(NB), .DWIDTH(DW), .AWIDTH(AB), .MAX_BURST(MB)) u_dut_b (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .bus        (if_b),
    .grant_id_o (gnt_b)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_b)
`endif
  );

  assign if_a.req_valid_i  = vld[0][NA-1:0];
  assign if_b.req_valid_i  = vld[1][NB-1:0];
  assign if_a.fifo_usedw_i = 3'(size[0]);
  assign if_b.fifo_usedw_i = 5'(size[1]);
  assign rdy_a = 16'(if_a.req_ready_o);
  assign rdy_b = 16'(if_b.req_ready_o);

  always_comb begin
    for (int i = 0; i < NA; i++) if_a.req_data_i[i*DW +: DW] = dat[0][i];
    for (int i = 0; i < NB; i++) if_b.req_data_i[i*DW +: DW] = dat[1][i];
  end

  // Reference model state: owner<0 means arbitrating
  typedef struct {
    int          owner;
    int          cnt;
    int          ptr;
    int          last;
    bit          wr;
    logic [31:0] wdata;
    int          stall;
  } model_t;
  model_t m [2];

  typedef struct {
    logic [3:0] valid;
    int         usedw;
    logic [3:0] ready;
  } vec_t;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Arbitration rules evaluated for one cycle; returns expected ready vector
  task automatic model_step(input int d, input logic [15:0] v, output logic [15:0] er);
    int n, sel, idx, own;
    bit space, acc;
    n     = nreq[d];
    sel   = -1;
    own   = m[d].owner;
    space = (size[d] + (m[d].wr ? 1 : 0)) < depth[d];
    if (own < 0) begin
      for (int k = 0; k < n; k++) begin
        idx = (m[d].ptr + k) % n;
        if (sel < 0 && v[idx[3:0]]) sel = idx;
      end
    end else if (v[own[3:0]]) begin
      sel = own;
    end
    acc = space && (sel >= 0);
    er  = acc ? (16'(1) << sel) : 16'(0);
    if ((v != 16'd0) && !space && m[d].stall < 65535) m[d].stall++;
    if (own < 0) begin
      if (acc) begin
        m[d].last = sel;
        if (mburst[d] > 1) begin
          m[d].owner = sel;
          m[d].cnt   = 1;
        end else begin
          m[d].ptr = (sel + 1) % n;
        end
      end
    end else if (!v[own[3:0]]) begin
      m[d].ptr   = (own + 1) % n;
      m[d].owner = -1;
      m[d].cnt   = 0;
    end else if (acc) begin
      m[d].cnt++;
      if (m[d].cnt == mburst[d]) begin
        m[d].ptr   = (own + 1) % n;
        m[d].owner = -1;
      end
    end
    m[d].wr = acc;
    if (acc) m[d].wdata = dat[d][sel[3:0]];
  endtask

  task automatic clear_models();
    for (int d = 0; d < 2; d++) begin
      m[d].owner = -1;
      m[d].cnt   = 0;
      m[d].ptr   = 0;
      m[d].last  = 0;
      m[d].wr    = 1'b0;
      m[d].wdata = '0;
      m[d].stall = 0;
      size[d]    = 0;
      pend_wr[d] = 1'b0;
      pend_rd[d] = 1'b0;
    end
  endtask

  // Assert reset with every producer valid; nothing may be offered or written
  task automatic do_reset();
    @(negedge clk);
    arstn  = 1'b0;
    vld[0] = 16'hFFFF;
    vld[1] = 16'hFFFF;
    clear_models();
    #1;
    check("rst_ready", 0, 32'(rdy_a), 32'd0);
    check("rst_ready", 1, 32'(rdy_b), 32'd0);
    check("rst_wrreq", 0, 32'(if_a.fifo_wrreq_o), 32'd0);
    check("rst_wrreq", 1, 32'(if_b.fifo_wrreq_o), 32'd0);
    check("rst_data", 0, if_a.fifo_data_o, 32'd0);
    check("rst_grant", 1, 32'(gnt_b), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_ready_hold", 0, 32'(rdy_a), 32'd0);
    arstn  = 1'b1;
    vld[0] = '0;
    vld[1] = '0;
  endtask

  // One clock: check registered outputs, advance fifo model, drive, check ready
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input bit rda, input bit rdb,
                      output logic [15:0] ra, output logic [15:0] rb);
    logic [15:0] er;
    logic        wr_o;
    logic [31:0] d_o;
    int          g_o;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      wr_o = (d == 0) ? if_a.fifo_wrreq_o : if_b.fifo_wrreq_o;
      d_o  = (d == 0) ? if_a.fifo_data_o : if_b.fifo_data_o;
      g_o  = (d == 0) ? int'(gnt_a) : int'(gnt_b);
      check("wrreq", d, 32'(wr_o), 32'(m[d].wr));
      if (wr_o && m[d].wr) check("wdata", d, d_o, m[d].wdata);
      check("grant", d, 32'(g_o), 32'(m[d].last));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
      check("stall_cnt", d, 32'((d == 0) ? stall_a : stall_b), 32'(m[d].stall));
`endif
      if (pend_wr[d]) begin
        check("no_overflow", d, 32'(size[d] < depth[d]), 32'd1);
        size[d]++;
      end
      if (pend_rd[d]) size[d]--;
      pend_wr[d] = wr_o;
    end
    pend_rd[0] = rda && (size[0] > 0);
    pend_rd[1] = rdb && (size[1] > 0);
    vld[0] = va & 16'h000F;
    vld[1] = vb & 16'h0007;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) dat[d][i] = $urandom;
    #1;
    ra = rdy_a;
    rb = rdy_b;
    model_step(0, vld[0], er);
    check("ready", 0, 32'(ra), 32'(er));
    model_step(1, vld[1], er);
    check("ready", 1, 32'(rb), 32'(er));
  endtask

  initial begin
    vec_t        tbl [8];
    logic [3:0]  e3 [9];
    logic [3:0]  ed [4];
    logic [3:0]  e4 [10];
    logic [3:0]  e5 [4];
    logic [2:0]  e2 [5];
    logic [15:0] ra, rb, va, vb;

    tbl[0] = '{4'b1111, 0, 4'b0001};
    tbl[1] = '{4'b1110, 0, 4'b0010};
    tbl[2] = '{4'b1000, 0, 4'b1000};
    tbl[3] = '{4'b0000, 0, 4'b0000};
    tbl[4] = '{4'b1111, 4, 4'b0000};
    tbl[5] = '{4'b1111, 3, 4'b0001};
    tbl[6] = '{4'b0110, 2, 4'b0010};
    tbl[7] = '{4'b0101, 3, 4'b0001};
    e3 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    ed = '{4'b0010, 4'b0010, 4'b0000, 4'b0100};
    e4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    e5 = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
    e2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

    arstn  = 1'b0;
    vld[0] = '0;
    vld[1] = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) dat[d][i] = '0;
    clear_models();

    // First-cycle selection right after reset, including occupancy limits
    for (int i = 0; i < 8; i++) begin
      do_reset();
      vld[0]  = 16'(tbl[i].valid);
      size[0] = tbl[i].usedw;
      #1;
      check($sformatf("table%0d_ready", i), 0, 32'(rdy_a), 32'(tbl[i].ready));
    end

    // Bursts of 4 from producer 1 then 2, fifo drained
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(16'h6, 16'h0, 1'b1, 1'b0, ra, rb);
      check($sformatf("burst_seq%0d", i), 0, 32'(ra), 32'(e3[i]));
    end

    // Owner drops valid mid-burst: one idle cycle, then the other producer
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step((i < 2) ? 16'h6 : 16'h4, 16'h0, 1'b1, 1'b0, ra, rb);
      check($sformatf("drop_seq%0d", i), 0, 32'(ra), 32'(ed[i]));
    end

    // Fill a depth-4 fifo with no reads: exactly four writes, then blocked
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(16'hF, 16'h0, 1'b0, 1'b0, ra, rb);
      check($sformatf("fill_seq%0d", i), 0, 32'(ra), 32'(e4[i]));
    end
    check("fill_usedw", 0, 32'(size[0]), 32'd4);

    // One read frees a slot; the in-flight write closes it again
    for (int i = 0; i < 4; i++) begin
      step(16'hF, 16'h0, i == 0, 1'b0, ra, rb);
      check($sformatf("refill_seq%0d", i), 0, 32'(ra), 32'(e5[i]));
    end

    // Pure round robin over three producers wraps 2 -> 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(16'h0, 16'h7, 1'b0, 1'b1, ra, rb);
      check($sformatf("rr_seq%0d", i), 1, 32'(rb), 32'(e2[i]));
    end

    // Random traffic with occasional mid-stream reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) do_reset();
      va = 16'($urandom) | 16'($urandom);
      vb = 16'($urandom) | 16'($urandom);
      step(va, vb, $urandom_range(1, 0) == 1, $urandom_range(4, 0) != 0, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
